// File: rtl/k_and_s_pkg.sv
//------------------------------------------------------------------------------
// Module  : k_and_s_pkg
// Brief   : Shared types and constants for the K&S RAM port arbiter.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package k_and_s_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CPU  = 2'd1,
        ARB_HOST = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_PORT_CPU  = 1'b0,
        ARB_PORT_HOST = 1'b1
    } arb_port_t;

    localparam int KS_RAM_RD_LAT = 1;

endpackage

`default_nettype wire

// File: rtl/ks_arb_pick.sv
//------------------------------------------------------------------------------
// Module  : ks_arb_pick
// Brief   : Combinational winner select from an eligible mask and a last-served
//           pointer (pointer ignored when RR_EN = 0, host wins every tie).
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ks_arb_pick
    import k_and_s_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic [1:0] i_elig,       // [0] = core, [1] = host
    input  arb_port_t  i_last_port,
    output logic       o_vld,
    output arb_port_t  o_port
);

    logic w_host_first;

    always_comb begin
        w_host_first = !RR_EN || (i_last_port == ARB_PORT_CPU);
        o_vld        = |i_elig;
        o_port       = ARB_PORT_CPU;
        if (i_elig[1] && (!i_elig[0] || w_host_first)) begin
            o_port = ARB_PORT_HOST;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
//------------------------------------------------------------------------------
// Module  : ram_port_arbiter
// Brief   : Shares the single-port program/data RAM between the core and the
//           host loader port. Optional macro KS_ARB_ROUND_ROBIN_EN selects
//           round-robin tie-break instead of fixed host priority.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_port_arbiter
    import k_and_s_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_lock,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              w_elig_cpu;
    logic              w_elig_host;
    logic              w_pick_vld;
    arb_port_t         w_pick_port;
    arb_port_t         w_last_port;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_ram_we;
    logic              r_cpu_rvalid;
    logic              r_host_rvalid;

`ifdef KS_ARB_ROUND_ROBIN_EN
    localparam bit c_rr_en = 1'b1;

    arb_port_t r_last_port;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_port <= ARB_PORT_CPU;
        end else if (w_pick_vld) begin
            r_last_port <= w_pick_port;
        end
    end

    assign w_last_port = r_last_port;
`else
    localparam bit c_rr_en = 1'b0;

    assign w_last_port = ARB_PORT_CPU;
`endif

    // The current owner's request is masked so a lone requester idles one cycle
    assign w_elig_host = host_req & (r_state != ARB_HOST);
    assign w_elig_cpu  = cpu_req & ~host_lock & (r_state != ARB_CPU);

    ks_arb_pick #(
        .RR_EN(c_rr_en)
    ) u_pick (
        .i_elig     ({w_elig_host, w_elig_cpu}),
        .i_last_port(w_last_port),
        .o_vld      (w_pick_vld),
        .o_port     (w_pick_port)
    );

    always_comb begin
        w_state_nxt = ARB_IDLE;
        w_sel_we    = cpu_we;
        w_sel_addr  = cpu_addr;
        w_sel_wdata = cpu_wdata;
        if (w_pick_vld) begin
            if (w_pick_port == ARB_PORT_HOST) begin
                w_state_nxt = ARB_HOST;
                w_sel_we    = host_we;
                w_sel_addr  = host_addr;
                w_sel_wdata = host_wdata;
            end else begin
                w_state_nxt = ARB_CPU;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ARB_IDLE;
            r_ram_addr    <= '0;
            r_ram_wdata   <= '0;
            r_ram_we      <= 1'b0;
            r_cpu_rvalid  <= 1'b0;
            r_host_rvalid <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ram_we <= w_pick_vld & w_sel_we;
            if (w_pick_vld) begin
                r_ram_addr  <= w_sel_addr;
                r_ram_wdata <= w_sel_wdata;
            end
            r_cpu_rvalid  <= (r_state == ARB_CPU) & ~r_ram_we;
            r_host_rvalid <= (r_state == ARB_HOST) & ~r_ram_we;
        end
    end

    assign cpu_gnt     = (r_state == ARB_CPU);
    assign host_gnt    = (r_state == ARB_HOST);
    assign cpu_stall   = cpu_req & ~cpu_gnt;
    assign cpu_rvalid  = r_cpu_rvalid;
    assign host_rvalid = r_host_rvalid;
    assign cpu_rdata   = ram_rdata;
    assign host_rdata  = ram_rdata;
    assign ram_addr    = r_ram_addr;
    assign ram_wdata   = r_ram_wdata;
    assign ram_we      = r_ram_we;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_ram_port_arbiter
// Brief   : Self-checking bench for ram_port_arbiter with a behavioural RAM and
//           read-data scoreboards per port.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_port_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_gnt, cpu_rvalid, cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [DATA_W-1:0] host_wdata = '0;
    logic              host_gnt, host_rvalid;
    logic [DATA_W-1:0] host_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    logic [DATA_W-1:0] mem    [32];
    logic [DATA_W-1:0] shadow [32];
    logic [DATA_W-1:0] cpu_q  [$];
    logic [DATA_W-1:0] host_q [$];
    int                n_checks = 0;
    int                n_fail   = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_lock  (host_lock),
        .host_gnt   (host_gnt),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata)
    );

    function automatic logic [DATA_W-1:0] init_val(input int i);
        return (i == 5) ? 16'hBEEF : 16'(i * 257);
    endfunction

    // Synchronous-read RAM: data for the address presented in cycle N+1 appears in N+2
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
            ram_rdata <= '0;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            cpu_q.delete();
            host_q.delete();
        end else begin
            if (cpu_rvalid) begin
                if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", 1, 0);
                else check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
            end
            if (host_rvalid) begin
                if (host_q.size() == 0) check("host_rvalid_unexpected", 1, 0);
                else check("host_rdata", host_rdata, host_q.pop_front());
            end
            if (ram_we) check("ram_we_owner", cpu_gnt | host_gnt, 1);
        end
    end

    // Request fields must stay put until granted
    assert property (@(posedge clk) disable iff (!rst_n)
        cpu_req && !cpu_gnt |=> !cpu_req || ($stable(cpu_addr) && $stable(cpu_we) && $stable(cpu_wdata)))
        else $error("cpu request changed before grant");
    assert property (@(posedge clk) disable iff (!rst_n)
        host_req && !host_gnt |=> !host_req || ($stable(host_addr) && $stable(host_we) && $stable(host_wdata)))
        else $error("host request changed before grant");

    task automatic cpu_access(input logic we, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] data, output int waits);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
        if (we) shadow[addr] = data;
        else cpu_q.push_back(shadow[addr]);
        waits = 0;
        @(negedge clk);
        while (!cpu_gnt && waits < 20) begin
            check("cpu_stall_wait", cpu_stall, 1);
            waits++;
            @(negedge clk);
        end
        if (!cpu_gnt) begin
            check("cpu_gnt_timeout", 0, 1);
        end else begin
            check("cpu_ram_addr", ram_addr, addr);
            check("cpu_ram_we", ram_we, we);
            if (we) check("cpu_ram_wdata", ram_wdata, data);
            check("cpu_stall_at_gnt", cpu_stall, 0);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic host_access(input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data, output int waits);
        @(posedge clk); #1;
        host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = data;
        if (we) shadow[addr] = data;
        else host_q.push_back(shadow[addr]);
        waits = 0;
        @(negedge clk);
        while (!host_gnt && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!host_gnt) begin
            check("host_gnt_timeout", 0, 1);
        end else begin
            check("host_ram_addr", ram_addr, addr);
            check("host_ram_we", ram_we, we);
            if (we) check("host_ram_wdata", ram_wdata, data);
        end
        @(posedge clk); #1;
        host_req = 1'b0;
    endtask

    initial begin
        int w;
        for (int i = 0; i < 32; i++) shadow[i] = init_val(i);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cpu_gnt", cpu_gnt, 0);
        check("rst_host_gnt", host_gnt, 0);
        check("rst_cpu_rvalid", cpu_rvalid, 0);
        check("rst_host_rvalid", host_rvalid, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_cpu_stall", cpu_stall, 0);
        rst_n = 1'b1;

        // Reset in the middle of a host read
        @(posedge clk); #1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 5'd9;
        w = 0;
        @(negedge clk);
        while (!host_gnt && w < 20) begin w++; @(negedge clk); end
        check("t1_host_gnt_before_rst", host_gnt, 1);
        rst_n = 1'b0;
        #1;
        check("t1_host_gnt_in_rst", host_gnt, 0);
        check("t1_ram_we_in_rst", ram_we, 0);
        @(negedge clk);
        check("t1_host_rvalid_dropped", host_rvalid, 0);
        check("t1_ram_addr_rst", ram_addr, 0);
        host_req = 1'b0;
        rst_n = 1'b1;

        // Both ports requesting continuously: H,C,H,C with RAM busy every cycle
        @(posedge clk); #1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 5'd5;
        cpu_req  = 1'b1; cpu_we  = 1'b0; cpu_addr  = 5'd7;
        repeat (4) host_q.push_back(shadow[5]);
        repeat (3) cpu_q.push_back(shadow[7]);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("t4_host_gnt_c%0d", c), host_gnt, (c % 2 == 0));
            check($sformatf("t4_cpu_gnt_c%0d", c), cpu_gnt, (c >= 3 && c % 2 == 1));
            if (c >= 2) check($sformatf("t4_busy_c%0d", c), host_gnt | cpu_gnt, 1);
        end
        host_req = 1'b0;
        cpu_req  = 1'b0;
        repeat (2) @(negedge clk);

        // Lone core read of address 5
        cpu_access(1'b0, 5'd5, 16'h0, w);
        check("t2_cpu_wait_cycles", w, 1);

        // Host write then core read-back
        host_access(1'b1, 5'd3, 16'h1234, w);
        check("t3_host_wait_cycles", w, 1);
        cpu_access(1'b0, 5'd3, 16'h0, w);
        check("t3_cpu_wait_cycles", w, 1);

        // Host lock holds the core off
        @(posedge clk); #1;
        host_lock = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd3;
        cpu_q.push_back(shadow[3]);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("t5_locked_gnt", cpu_gnt, 0);
            check("t5_locked_stall", cpu_stall, 1);
        end
        @(posedge clk); #1;
        host_lock = 1'b0;
        @(negedge clk);
        check("t5_unlock_gnt_c1", cpu_gnt, 0);
        @(negedge clk);
        check("t5_unlock_gnt_c2", cpu_gnt, 1);
        @(posedge clk); #1;
        cpu_req = 1'b0;

        // Core alone holding request: grant every other cycle
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd12;
        repeat (3) cpu_q.push_back(shadow[12]);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check($sformatf("t6_cpu_gnt_c%0d", c), cpu_gnt, (c % 2 == 0));
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;

        repeat (4) @(negedge clk);
        check("cpu_q_drained", cpu_q.size(), 0);
        check("host_q_drained", host_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
